// File: rtl/count8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count8_ctrl_pkg
// Description : Shared types and constants for the count8_ctrl sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package count8_ctrl_pkg;

  // Default counter / value width.
  localparam int CNT_WIDTH = 8;

  // Sequencer states; the encoding is fixed so that state dumps are readable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : count8_ctrl_pkg
`default_nettype wire

// File: rtl/count8_ctrl_periods.sv
`default_nettype none
// ============================================================================
// Module      : count8_ctrl_periods
// Description : Wrapping completed-period counter with clear and increment.
// Revision    : 1.0 - initial release
// ============================================================================
module count8_ctrl_periods
  import count8_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: clear wins over increment; increment wraps with no saturation.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Period count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : count8_ctrl_periods
`default_nettype wire

// File: rtl/count8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : count8_ctrl
// Description : Sequencer driving an 8-bit loadable up-counter: accepts a run
//               command, loads the counter, counts to the terminal value,
//               pulses done, optionally reloads for periodic operation.
// Revision    : 1.0 - initial release
// ============================================================================
module count8_ctrl
  import count8_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_periodic,
  input  logic             stop,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] periods
);

  state_e           state_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;

  logic w_idle;
  logic w_accept;
  logic w_at_limit;
  logic w_period_done;

  assign w_idle        = (state_q == ST_IDLE);
  assign w_accept      = w_idle & cmd_valid;
  // Compare is taken directly on the live counter output, no pipeline stage.
  assign w_at_limit    = (cnt_val == limit_q);
  // A period only completes when DONE is left without an abort.
  assign w_period_done = (state_q == ST_DONE) & ~stop;

  // Sequencer FSM and command capture; stop aborts from any busy state.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            start_q    <= cmd_start;
            limit_q    <= cmd_limit;
            periodic_q <= cmd_periodic;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q <= stop ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (w_at_limit) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= periodic_q ? ST_LOAD : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state; stop gates the counter controls and done.
  assign cmd_ready = w_idle;
  assign busy      = ~w_idle;
  assign cnt_in    = w_idle ? '0 : start_q;
  assign cnt_load  = (state_q == ST_LOAD) & ~stop;
  assign cnt_en    = ((state_q == ST_LOAD) | ((state_q == ST_RUN) & ~w_at_limit)) & ~stop;
  assign done      = w_period_done;

  count8_ctrl_periods #(
    .WIDTH (WIDTH)
  ) u_periods (
    .clk     (clk),
    .res     (res),
    .clr_i   (w_accept),
    .inc_i   (w_period_done),
    .count_o (periods)
  );

endmodule : count8_ctrl
`default_nettype wire

// File: tb/tb_count8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_count8_ctrl
// Description : Directed self-checking bench for count8_ctrl, with a simple
//               behavioural model of the loadable up-counter it drives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count8_ctrl;

  logic       clk = 1'b0;
  logic       res;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_start;
  logic [7:0] cmd_limit;
  logic       cmd_periodic;
  logic       stop;
  logic       cnt_en;
  logic       cnt_load;
  logic [7:0] cnt_in;
  logic [7:0] cnt_val = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] periods;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External counter: EN gates everything, load selects CNT_In.
  always @(posedge clk) begin
    if (cnt_en) cnt_val <= cnt_load ? cnt_in : cnt_val + 8'd1;
  end

  count8_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .res          (res),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_start    (cmd_start),
    .cmd_limit    (cmd_limit),
    .cmd_periodic (cmd_periodic),
    .stop         (stop),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_in       (cnt_in),
    .cnt_val      (cnt_val),
    .busy         (busy),
    .done         (done),
    .periods      (periods)
  );

  // Present a command for one edge; returns at the negedge of the LOAD cycle.
  task automatic issue(input logic [7:0] s, input logic [7:0] l, input logic p);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = s; cmd_limit = l; cmd_periodic = p;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0; cmd_valid = 1'b0; stop = 1'b0;
    cmd_start = 8'h00; cmd_limit = 8'h00; cmd_periodic = 1'b0;
    @(negedge clk); @(negedge clk);
    res = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if ({busy, done, cnt_en, cnt_load} !== 4'b0000) begin failures++; $display("FAIL reset_ctl got %b want 0000", {busy, done, cnt_en, cnt_load}); end
    checks++; if (cnt_in !== 8'h00) begin failures++; $display("FAIL reset_cnt_in got %h want 00", cnt_in); end
    checks++; if (periods !== 8'h00) begin failures++; $display("FAIL reset_periods got %h want 00", periods); end
  endtask

  task automatic test_oneshot();
    issue(8'h10, 8'h13, 1'b0);
    checks++; if ({cnt_load, cnt_en, busy, cmd_ready} !== 4'b1110) begin failures++; $display("FAIL os_load_ctl got %b want 1110", {cnt_load, cnt_en, busy, cmd_ready}); end
    checks++; if (cnt_in !== 8'h10) begin failures++; $display("FAIL os_cnt_in got %h want 10", cnt_in); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (cnt_val !== 8'h10 + 8'(i)) begin failures++; $display("FAIL os_run_val[%0d] got %h want %h", i, cnt_val, 8'h10 + 8'(i)); end
      checks++; if ({cnt_en, cnt_load, done} !== {(i != 3), 2'b00}) begin failures++; $display("FAIL os_run_ctl[%0d] got %b want %b", i, {cnt_en, cnt_load, done}, {(i != 3), 2'b00}); end
    end
    @(negedge clk);
    checks++; if ({done, cnt_en} !== 2'b10) begin failures++; $display("FAIL os_done got %b want 10", {done, cnt_en}); end
    @(negedge clk);
    checks++; if ({done, cmd_ready, busy} !== 3'b010) begin failures++; $display("FAIL os_idle got %b want 010", {done, cmd_ready, busy}); end
    checks++; if (periods !== 8'h01) begin failures++; $display("FAIL os_periods got %h want 01", periods); end
  endtask

  task automatic test_wrap();
    logic [31:0] seen;
    int          cyc;
    seen = 32'h0;
    cyc  = 1;
    issue(8'hFE, 8'h01, 1'b0);
    // Cycle 1 is LOAD; collect RUN values until done, bounded.
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!done) seen = {seen[23:0], cnt_val};
    end
    checks++; if (cyc !== 6) begin failures++; $display("FAIL wrap_done_cycle got %0d want 6", cyc); end
    checks++; if (seen !== 32'hFEFF0001) begin failures++; $display("FAIL wrap_values got %h want FEFF0001", seen); end
    @(negedge clk);
  endtask

  task automatic test_periodic();
    int bad_done;
    int bad_ready;
    bad_done  = 0;
    bad_ready = 0;
    issue(8'h00, 8'h02, 1'b1);
    for (int c = 1; c <= 1501; c++) begin
      if (c > 1) @(negedge clk);
      if (done !== ((c % 5) == 0)) bad_done++;
      if (cmd_ready !== 1'b0) bad_ready++;
    end
    checks++; if (bad_done !== 0) begin failures++; $display("FAIL per_done_spacing got %0d bad cycles want 0", bad_done); end
    checks++; if (bad_ready !== 0) begin failures++; $display("FAIL per_ready_low got %0d bad cycles want 0", bad_ready); end
    checks++; if (periods !== 8'h2C) begin failures++; $display("FAIL per_periods got %h want 2c", periods); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if ({cmd_ready, periods} !== {1'b1, 8'h2C}) begin failures++; $display("FAIL per_stop got %b/%h want 1/2c", cmd_ready, periods); end
  endtask

  task automatic test_equal();
    issue(8'h55, 8'h55, 1'b0);
    @(negedge clk);
    checks++; if ({cnt_val, cnt_en, done, busy} !== {8'h55, 3'b001}) begin failures++; $display("FAIL eq_run got %h/%b want 55/001", cnt_val, {cnt_en, done, busy}); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL eq_done got %b want 1", done); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL eq_idle got %b want 1", cmd_ready); end
  endtask

  task automatic test_abort_run();
    int n;
    n = 0;
    issue(8'h10, 8'h20, 1'b0);
    while (cnt_val !== 8'h12 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL ab_reach got %0d cycles want 3", n); end
    checks++; if (cnt_en !== 1'b1) begin failures++; $display("FAIL ab_en_pre got %b want 1", cnt_en); end
    stop = 1'b1;
    #1;
    checks++; if ({cnt_en, cnt_load, done} !== 3'b000) begin failures++; $display("FAIL ab_gate got %b want 000", {cnt_en, cnt_load, done}); end
    @(negedge clk);
    stop = 1'b0;
    checks++; if ({cmd_ready, busy, done} !== 3'b100) begin failures++; $display("FAIL ab_idle got %b want 100", {cmd_ready, busy, done}); end
    checks++; if ({periods, cnt_val} !== {8'h00, 8'h12}) begin failures++; $display("FAIL ab_state got %h/%h want 00/12", periods, cnt_val); end
  endtask

  task automatic test_abort_done();
    issue(8'h30, 8'h31, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL abd_pre got %b want 1", done); end
    stop = 1'b1;
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abd_gate got %b want 0", done); end
    @(negedge clk);
    stop = 1'b0;
    checks++; if ({cmd_ready, periods} !== {1'b1, 8'h00}) begin failures++; $display("FAIL abd_idle got %b/%h want 1/00", cmd_ready, periods); end
  endtask

  task automatic test_reset_midrun();
    issue(8'h40, 8'h41, 1'b1);
    // Period is 4 cycles; by cycle 10 two periods are complete and RUN is active.
    for (int c = 2; c <= 10; c++) @(negedge clk);
    checks++; if ({periods, busy, cnt_in} !== {8'h02, 1'b1, 8'h40}) begin failures++; $display("FAIL rm_pre got %h/%b/%h want 02/1/40", periods, busy, cnt_in); end
    res = 1'b0;
    @(negedge clk);
    res = 1'b1;
    checks++; if ({cmd_ready, busy, done, cnt_en, cnt_load} !== 5'b10000) begin failures++; $display("FAIL rm_ctl got %b want 10000", {cmd_ready, busy, done, cnt_en, cnt_load}); end
    checks++; if ({cnt_in, periods} !== 16'h0000) begin failures++; $display("FAIL rm_vals got %h/%h want 00/00", cnt_in, periods); end
  endtask

  task automatic test_cmd_ignored();
    issue(8'h60, 8'h62, 1'b0);
    cmd_valid = 1'b1; cmd_start = 8'h00; cmd_limit = 8'h70; cmd_periodic = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checks++; if ({cmd_ready, cnt_in} !== {1'b0, 8'h60}) begin failures++; $display("FAIL ig_run[%0d] got %b/%h want 0/60", c, cmd_ready, cnt_in); end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if ({done, cnt_val} !== {1'b1, 8'h62}) begin failures++; $display("FAIL ig_done got %b/%h want 1/62", done, cnt_val); end
    @(negedge clk);
    checks++; if ({cmd_ready, periods} !== {1'b1, 8'h01}) begin failures++; $display("FAIL ig_idle got %b/%h want 1/01", cmd_ready, periods); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_wrap();
    test_periodic();
    test_equal();
    test_abort_run();
    test_abort_done();
    test_reset_midrun();
    test_cmd_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_count8_ctrl
`default_nettype wire
